// File: rtl/spi_host.sv
// spi_host: SPI mode-0 controller (CPOL=0, CPHA=0), host end of the servant config port.
// Accepts words over a valid/ready stream, keeps CS low across a multi-word frame,
// and emits each received word as a one-cycle strobe.
// Optional feature macro: SPI_HOST_LSB_FIRST_EN (shift LSB first); default is MSB first.
module spi_host #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              wb_clk,
  input  logic              i_nrst,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_last,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              o_sck,
  output logic              o_copi,
  input  logic              i_cipo,
  output logic              o_cs
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_END   = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              last_q;
  logic              sck_q;
  logic              copi_q;
  logic              cs_q;
  logic              rx_valid_q;

  logic              accept_s;
  logic              div_end_s;
  logic [DATA_W-1:0] tx_shift_d;
  logic [DATA_W-1:0] rx_shift_d;

  // Bit presented on COPI for a word whose next bit sits at the shift-out end.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_HOST_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  // Advance the transmit word by one bit toward the shift-out end.
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
`ifdef SPI_HOST_LSB_FIRST_EN
    return w >> 1;
`else
    return w << 1;
`endif
  endfunction

  // Insert one sampled CIPO bit so the first bit ends at the first-bit position.
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
`ifdef SPI_HOST_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  // Handshake, divider terminal count, shift helpers and output decode.
  always_comb begin
    o_tx_ready = i_nrst & ((state_q == S_IDLE) | (state_q == S_WAIT));
    accept_s   = i_tx_valid & o_tx_ready;
    div_end_s  = (div_q == DIV_LAST);
    tx_shift_d = tx_shift(tx_q);
    rx_shift_d = rx_shift(rx_q, i_cipo);
    o_busy     = (state_q != S_IDLE);
    o_sck      = sck_q;
    o_copi     = copi_q;
    o_cs       = cs_q;
    o_rx_valid = rx_valid_q;
    o_rx_data  = rx_data_q;
  end

  // Frame sequencer: CS framing, SCK generation, shifting and receive strobe.
  always_ff @(posedge wb_clk) begin
    if (!i_nrst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      copi_q     <= 1'b0;
      cs_q       <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cs_q  <= 1'b1;
          sck_q <= 1'b0;
          if (accept_s) begin
            tx_q    <= i_tx_data;
            last_q  <= i_tx_last;
            copi_q  <= first_bit(i_tx_data);
            cs_q    <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_WAIT: begin
          // CS stays low between words of one frame; waits as long as needed.
          sck_q <= 1'b0;
          if (accept_s) begin
            tx_q    <= i_tx_data;
            last_q  <= i_tx_last;
            copi_q  <= first_bit(i_tx_data);
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_end_s) begin
            div_q   <= '0;
            state_q <= S_SHIFT;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          if (bit_q == BIT_LAST) begin
            // Cycle after the final falling edge: publish the word.
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_q;
            bit_q      <= '0;
            div_q      <= '0;
            state_q    <= last_q ? S_END : S_WAIT;
          end else if (div_end_s) begin
            div_q <= '0;
            if (!sck_q) begin
              // Rising edge: CIPO captured in the same cycle SCK goes high.
              sck_q <= 1'b1;
              rx_q  <= rx_shift_d;
            end else begin
              // Falling edge: present the next transmit bit.
              sck_q  <= 1'b0;
              bit_q  <= bit_q + BIT_W'(1);
              tx_q   <= tx_shift_d;
              copi_q <= first_bit(tx_shift_d);
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_END: begin
          if (div_end_s) begin
            div_q   <= '0;
            cs_q    <= 1'b1;
            state_q <= S_GAP;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (div_end_s) begin
            div_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          div_q   <= '0;
          bit_q   <= '0;
          sck_q   <= 1'b0;
          cs_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed checks of spi_host. Instance A runs CLK_DIV=2 against a mode-0
// servant model on CIPO; instance B runs CLK_DIV=1 with CIPO looped back from COPI.
module tb_spi_host;

  logic wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int cyc = 0;
  // Free-running cycle count for latency and SCK period measurements.
  always @(posedge wb_clk) cyc <= cyc + 1;

  logic nrst;

  logic [7:0] a_tx_data, a_rx;
  logic a_tx_last, a_tx_valid, a_ready, a_rxv, a_busy, a_sck, a_copi, a_cs;
  logic a_cipo = 1'b0;

  logic [7:0] b_tx_data, b_rx;
  logic b_tx_last, b_tx_valid, b_ready, b_rxv, b_busy, b_sck, b_copi, b_cs;

  spi_host #(.DATA_W(8), .CLK_DIV(2)) dut_a (
    .wb_clk(wb_clk), .i_nrst(nrst), .i_tx_data(a_tx_data), .i_tx_last(a_tx_last),
    .i_tx_valid(a_tx_valid), .o_tx_ready(a_ready), .o_rx_data(a_rx), .o_rx_valid(a_rxv),
    .o_busy(a_busy), .o_sck(a_sck), .o_copi(a_copi), .i_cipo(a_cipo), .o_cs(a_cs)
  );

  spi_host #(.DATA_W(8), .CLK_DIV(1)) dut_b (
    .wb_clk(wb_clk), .i_nrst(nrst), .i_tx_data(b_tx_data), .i_tx_last(b_tx_last),
    .i_tx_valid(b_tx_valid), .o_tx_ready(b_ready), .o_rx_data(b_rx), .o_rx_valid(b_rxv),
    .o_busy(b_busy), .o_sck(b_sck), .o_copi(b_copi), .i_cipo(b_copi), .o_cs(b_cs)
  );

  // Servant model state and wire monitors for instance A.
  logic [7:0] slv_words [4];
  logic [1:0] slv_w = 2'd0;
  logic [2:0] slv_b = 3'd0;
  int a_rise_n = 0, a_rxv_n = 0, a_csr_n = 0, a_rdy_lo_n = 0, a_glitch_n = 0;
  int a_rise_cyc [256];
  logic a_rise_bit [256];
  logic [7:0] a_rx_log [256];
  logic a_sck_p = 1'b0, a_cs_p = 1'b1;

  function automatic logic slv_bit(input logic [7:0] w, input logic [2:0] b);
`ifdef SPI_HOST_LSB_FIRST_EN
    return w[b];
`else
    return w[3'd7 - b];
`endif
  endfunction

  // COPI bits in wire order, first bit placed at the MSB.
  function automatic logic [7:0] exp_wire(input logic [7:0] w);
    logic [7:0] r;
`ifdef SPI_HOST_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  // Mode-0 servant: first bit ready while CS is high, next bit after each SCK fall; plus A monitors.
  always @(negedge wb_clk) begin
    if (a_cs) begin
      slv_w  <= 2'd0;
      slv_b  <= 3'd0;
      a_cipo <= slv_bit(slv_words[0], 3'd0);
    end else if (a_sck_p && !a_sck) begin
      if (slv_b == 3'd7) begin
        slv_w  <= slv_w + 2'd1;
        slv_b  <= 3'd0;
        a_cipo <= slv_bit(slv_words[slv_w + 2'd1], 3'd0);
      end else begin
        slv_b  <= slv_b + 3'd1;
        a_cipo <= slv_bit(slv_words[slv_w], slv_b + 3'd1);
      end
    end
    if (!a_sck_p && a_sck) begin
      a_rise_cyc[8'(a_rise_n)] <= cyc;
      a_rise_bit[8'(a_rise_n)] <= a_copi;
      a_rise_n <= a_rise_n + 1;
    end
    if (a_rxv) begin
      a_rx_log[8'(a_rxv_n)] <= a_rx;
      a_rxv_n <= a_rxv_n + 1;
    end
    if (!a_cs_p && a_cs) a_csr_n <= a_csr_n + 1;
    if (a_ready && !a_cs) a_rdy_lo_n <= a_rdy_lo_n + 1;
    if (a_sck && a_cs) a_glitch_n <= a_glitch_n + 1;
    a_sck_p <= a_sck;
    a_cs_p  <= a_cs;
  end

  int b_rise_n = 0, b_per2_n = 0, b_rxv_n = 0, b_csf_n = 0, b_glitch_n = 0, b_last_rise = -100;
  logic [7:0] b_rx_log [256];
  logic b_sck_p = 1'b0, b_cs_p = 1'b1;

  // Instance B monitors: SCK period, receive log, CS falls, SCK activity with CS high.
  always @(negedge wb_clk) begin
    if (!b_sck_p && b_sck) begin
      b_rise_n <= b_rise_n + 1;
      if (cyc - b_last_rise == 2) b_per2_n <= b_per2_n + 1;
      b_last_rise <= cyc;
    end
    if (b_rxv) begin
      b_rx_log[8'(b_rxv_n)] <= b_rx;
      b_rxv_n <= b_rxv_n + 1;
    end
    if (b_cs_p && !b_cs) b_csf_n <= b_csf_n + 1;
    if (b_sck && b_cs) b_glitch_n <= b_glitch_n + 1;
    b_sck_p <= b_sck;
    b_cs_p  <= b_cs;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a word on host A (sel=0) or B (sel=1); acc is the cycle of the accepting edge.
  task automatic send(input bit sel, input logic [7:0] d, input logic l, output int acc);
    acc = -1;
    if (sel) begin
      b_tx_data = d; b_tx_last = l; b_tx_valid = 1'b1;
    end else begin
      a_tx_data = d; a_tx_last = l; a_tx_valid = 1'b1;
    end
    for (int k = 0; k < 200; k++) begin
      if (sel ? b_ready : a_ready) begin
        @(posedge wb_clk); #1;
        acc = cyc;
        break;
      end
      @(posedge wb_clk); #1;
    end
    check("accept_seen", 32'(acc >= 0), 32'd1);
  endtask

  task automatic wait_idle(input bit sel, output int done);
    done = -1;
    for (int k = 0; k < 400; k++) begin
      @(posedge wb_clk); #1;
      if (!(sel ? b_busy : a_busy)) begin
        done = cyc;
        break;
      end
    end
    check("idle_seen", 32'(done >= 0), 32'd1);
  endtask

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] slv;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, done, r0, x0, c0, g0, l0, p0, f0, per_bad;
    int b_acc [4];
    logic [7:0] seq;
    logic [7:0] bw [4];

    vecs[0] = '{tx: 8'hA5, slv: 8'h3C};
    vecs[1] = '{tx: 8'h00, slv: 8'hFF};
    vecs[2] = '{tx: 8'hFF, slv: 8'h00};
    vecs[3] = '{tx: 8'h1E, slv: 8'h81};
    vecs[4] = '{tx: 8'hC4, slv: 8'h6B};
    for (int i = 0; i < 4; i++) slv_words[i] = 8'h00;

    nrst = 1'b0;
    a_tx_data = 8'h00; a_tx_last = 1'b0; a_tx_valid = 1'b0;
    b_tx_data = 8'h00; b_tx_last = 1'b0; b_tx_valid = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_cs", a_cs, 1);
    check("rst_sck", a_sck, 0);
    check("rst_copi", a_copi, 0);
    check("rst_rxv", a_rxv, 0);
    check("rst_rx", a_rx, 0);
    check("rst_ready", a_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_b_cs", b_cs, 1);
    nrst = 1'b1;
    #1;
    check("ready_after_rst", a_ready, 1);

    // Single-word frames on A: latency, wire order, SCK period, received word.
    for (int v = 0; v < 5; v++) begin
      slv_words[0] = vecs[v].slv;
      r0 = a_rise_n; x0 = a_rxv_n; c0 = a_csr_n; g0 = a_glitch_n;
      send(1'b0, vecs[v].tx, 1'b1, acc);
      a_tx_valid = 1'b0;
      wait_idle(1'b0, done);
      @(posedge wb_clk); #1;
      check("latency", 32'(done - acc), 32'd39);
      check("sck_pulses", 32'(a_rise_n - r0), 32'd8);
      check("rx_strobes", 32'(a_rxv_n - x0), 32'd1);
      check("rx_data", a_rx_log[8'(x0)], vecs[v].slv);
      seq = 8'h00; per_bad = 0;
      for (int i = 0; i < 8; i++) begin
        seq = {seq[6:0], a_rise_bit[8'(r0 + i)]};
        if (i > 0 && (a_rise_cyc[8'(r0 + i)] - a_rise_cyc[8'(r0 + i - 1)]) != 4) per_bad++;
      end
      check("copi_wire", seq, exp_wire(vecs[v].tx));
      check("sck_period", 32'(per_bad), 32'd0);
      check("cs_high_after", a_cs, 1);
      check("cs_rises", 32'(a_csr_n - c0), 32'd1);
      check("sck_with_cs_high", 32'(a_glitch_n - g0), 32'd0);
    end

    // Three-word frame with valid held high.
    slv_words[0] = 8'hC1; slv_words[1] = 8'h5E; slv_words[2] = 8'h99;
    r0 = a_rise_n; x0 = a_rxv_n; c0 = a_csr_n; l0 = a_rdy_lo_n;
    send(1'b0, 8'h01, 1'b0, acc);
    send(1'b0, 8'h02, 1'b0, acc);
    send(1'b0, 8'h03, 1'b1, acc);
    a_tx_valid = 1'b0;
    wait_idle(1'b0, done);
    @(posedge wb_clk); #1;
    check("frame3_sck_pulses", 32'(a_rise_n - r0), 32'd24);
    check("frame3_strobes", 32'(a_rxv_n - x0), 32'd3);
    check("frame3_rx0", a_rx_log[8'(x0)], 8'hC1);
    check("frame3_rx1", a_rx_log[8'(x0 + 1)], 8'h5E);
    check("frame3_rx2", a_rx_log[8'(x0 + 2)], 8'h99);
    check("frame3_cs_rises", 32'(a_csr_n - c0), 32'd1);
    check("frame3_ready_cs_low", 32'(a_rdy_lo_n - l0), 32'd2);
    seq = 8'h00;
    for (int i = 8; i < 16; i++) seq = {seq[6:0], a_rise_bit[8'(r0 + i)]};
    check("frame3_copi_word1", seq, exp_wire(8'h02));

    // Back-to-back single-word frames on B, loopback.
    for (int i = 0; i < 4; i++) bw[i] = 8'($urandom_range(0, 255));
    x0 = b_rxv_n; p0 = b_per2_n; f0 = b_csf_n; g0 = b_glitch_n;
    for (int i = 0; i < 4; i++) send(1'b1, bw[i], 1'b1, b_acc[i]);
    b_tx_valid = 1'b0;
    wait_idle(1'b1, done);
    @(posedge wb_clk); #1;
    check("b_spacing", 32'(b_acc[1] - b_acc[0]), 32'd21);
    check("b_latency", 32'(done - b_acc[3]), 32'd20);
    check("b_strobes", 32'(b_rxv_n - x0), 32'd4);
    for (int i = 0; i < 4; i++) check("b_loopback", b_rx_log[8'(x0 + i)], bw[i]);
    check("b_cs_falls", 32'(b_csf_n - f0), 32'd4);
    check("b_period2", 32'(b_per2_n - p0), 32'd28);
    check("b_sck_with_cs_high", 32'(b_glitch_n - g0), 32'd0);

    // Reset during the fourth bit of a frame on A.
    slv_words[0] = 8'h3C;
    r0 = a_rise_n; x0 = a_rxv_n;
    send(1'b0, 8'h96, 1'b1, acc);
    a_tx_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge wb_clk); #1;
      if (a_rise_n - r0 >= 4) break;
    end
    check("reached_bit4", 32'(a_rise_n - r0), 32'd4);
    nrst = 1'b0;
    @(posedge wb_clk); #1;
    check("midrst_cs", a_cs, 1);
    check("midrst_sck", a_sck, 0);
    check("midrst_copi", a_copi, 0);
    check("midrst_rxv", a_rxv, 0);
    check("midrst_rx", a_rx, 0);
    check("midrst_ready", a_ready, 0);
    check("midrst_busy", a_busy, 0);
    @(posedge wb_clk); #1;
    nrst = 1'b1;
    repeat (40) @(posedge wb_clk);
    #1;
    check("midrst_no_strobe", 32'(a_rxv_n - x0), 32'd0);

    // Recovery frame after the reset.
    slv_words[0] = 8'hE7;
    r0 = a_rise_n; x0 = a_rxv_n;
    send(1'b0, 8'h5A, 1'b1, acc);
    a_tx_valid = 1'b0;
    wait_idle(1'b0, done);
    @(posedge wb_clk); #1;
    check("recover_latency", 32'(done - acc), 32'd39);
    check("recover_rx", a_rx_log[8'(x0)], 8'hE7);
    seq = 8'h00;
    for (int i = 0; i < 8; i++) seq = {seq[6:0], a_rise_bit[8'(r0 + i)]};
    check("recover_copi", seq, exp_wire(8'h5A));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
